bht_gshare: RTL and testbench
=============================

# bht_gshare

Parametrised successor to the 2-bit branch history table. It adds configurable counter width, global-history (gshare) indexing with speculative history update and misprediction recovery, and a sequential row-walking clear engine in place of a single-cycle table reset. It sits in the frontend beside the BTB and RAS. It gives one taken/valid prediction per instruction slot of the fetch block and is trained by the execute stage.

## Interface
- VLEN, 64, virtual address width
- INSTR_PER_FETCH, 2, instruction slots per fetch block (power of two)
- RVC, 1, compressed ISA enabled; OFFSET = RVC ? 1 : 2
- NR_ENTRIES, 1024, total counters; NR_ROWS = NR_ENTRIES/INSTR_PER_FETCH (power of two); IDX_BITS = clog2(NR_ROWS)
- CTR_BITS, 2, saturating counter width, legal 2..4; CTR_INIT = 2^(CTR_BITS-1) (weakly taken)
- HIST_BITS, 8, global history length, legal 1..IDX_BITS
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- flush_bp_i  in  1  invalidate all entries and clear history
- debug_mode_i  in  1  suppress training while high
- vpc_i  in  VLEN  fetch-block PC to predict
- spec_valid_i  in  1  push a predicted branch outcome into the history
- spec_taken_i  in  1  predicted direction pushed
- update_valid_i  in  1  resolved conditional branch
- update_pc_i  in  VLEN  PC of the resolved branch
- update_taken_i  in  1  resolved direction
- update_ghr_i  in  HIST_BITS  history snapshot taken when this branch was predicted
- mispredict_i  in  1  qualifies update_valid_i; restore history
- ghr_o  out  HIST_BITS  current speculative history, captured by the frontend as the snapshot
- pred_valid_o  out  INSTR_PER_FETCH  per-slot entry valid
- pred_taken_o  out  INSTR_PER_FETCH  per-slot predicted taken (counter MSB)
- init_busy_o  out  1  clear engine active

## Operation
- Storage is NR_ROWS x INSTR_PER_FETCH entries of {valid, counter[CTR_BITS-1:0]}. Storage has no reset and must map to RAM.
- Read row = vpc_i[IDX_BITS+ROW_ADDR_BITS+OFFSET-1 : ROW_ADDR_BITS+OFFSET] XOR zero-extended ghr_q, where ROW_ADDR_BITS = clog2(INSTR_PER_FETCH). Slot i reads column i of that row.
- Train row is the same function of update_pc_i and update_ghr_i. Train column = update_pc_i[ROW_ADDR_BITS+OFFSET-1:OFFSET] when RVC=1, else 0.
- Training applies when update_valid_i && !debug_mode_i && !init_busy_o:
  - valid is set to 1.
  - The counter increments on taken and decrements on not-taken.
  - The counter saturates at 2^CTR_BITS-1 and at 0.
- History, in priority order:
  - flush_bp_i: ghr_q = 0.
  - update_valid_i && mispredict_i: ghr_q = {update_ghr_i[HIST_BITS-2:0], update_taken_i}. When HIST_BITS=1, ghr_q = update_taken_i.
  - spec_valid_i: ghr_q = {ghr_q[HIST_BITS-2:0], spec_taken_i}.
- A mispredict in the same cycle as spec_valid_i discards the spec push.
- History updates are not gated by debug_mode_i.
- Clear FSM has two states, CLEAR and IDLE.
  - CLEAR, on each cycle:
    - writes {0, CTR_INIT} to every column of row clr_cnt;
    - increments clr_cnt;
    - moves to IDLE after writing row NR_ROWS-1.
  - IDLE: flush_bp_i moves to CLEAR with clr_cnt = 0.
  - CLEAR with flush_bp_i: restarts at clr_cnt = 0.
- init_busy_o = (state == CLEAR).
- While in CLEAR:
  - pred_valid_o and pred_taken_o are forced to 0;
  - training updates are dropped;
  - history updates still apply.

## Timing
- Reset values:
  - state = CLEAR, clr_cnt = 0, ghr_q = 0.
  - init_busy_o = 1, pred_valid_o = 0, pred_taken_o = 0, ghr_o = 0.
- Prediction is combinational from vpc_i and ghr_q, with zero latency.
- A training write lands at the next clk_i edge and is visible from the next cycle.
- A same-cycle read and write to the same entry returns the old value; there is no bypass.
- A history update is visible on ghr_o, and in read indexing, in the cycle after the push.
- A clear takes exactly NR_ROWS cycles after reset release or after the last flush_bp_i.
- Asserting rst_i mid-clear restarts the clear from row 0.

## Test plan
Bench configuration for all scenarios: NR_ENTRIES=16, INSTR_PER_FETCH=2, RVC=1, HIST_BITS=3, CTR_BITS=2. This gives 8 rows, read row = vpc[4:2]^ghr, column = vpc[1].

1. Reset and clear.
   - Stimulus: release rst_i, then drive lookups at every vpc.
   - Required: init_busy_o=1 for exactly 8 cycles, then 0; pred_valid_o=2'b00 at every vpc.
2. Saturation.
   - Stimulus: with ghr=0, three updates pc=0x8 taken, then three updates pc=0x8 not-taken.
   - Required: after the taken updates, counter reads 11; vpc=0x8 gives pred_valid_o[0]=1, pred_taken_o[0]=1. During the not-taken updates the counter goes 10, 01, 00, and pred_taken_o[0]=0 from the second one.
   - Repeat with CTR_BITS=3: the first read after training shows counter 101.
3. Speculative history.
   - Stimulus: push spec_taken 1, 0, 1.
   - Required: ghr_o=3'b101; vpc=0x0 reads row 5. Train pc=0x0 with update_ghr_i=3'b101, then lookup vpc=0x0: hit with valid=1.
4. Mispredict recovery.
   - Stimulus: ghr=3'b101; in one cycle assert mispredict_i, update_ghr_i=3'b011, update_taken_i=0 and spec_valid_i=1.
   - Required: ghr_o=3'b110 next cycle.
5. Flush during clear.
   - Stimulus: flush_bp_i in clear cycle 4, plus an update during the clear.
   - Required: init_busy_o stays high 8 further cycles; the dropped update leaves that entry with valid=0.
6. Debug mode and no-bypass.
   - Stimulus: a taken update with debug_mode_i=1; then, in normal mode, a same-cycle read and taken write to one entry.
   - Required: debug update leaves the counter unchanged. Same-cycle read returns the pre-write counter; the next cycle shows it incremented.

Source files
------------

// File: rtl/bht_gshare_if.sv
// bht_gshare_if: frontend <-> branch history table connection.
//
// The frontend (master) drives the lookup PC, speculative history pushes,
// training updates, flush and debug mode. The table (slave) returns the
// per-slot prediction, the speculative history snapshot, clear-engine busy
// and its FSM state for observation.
//
// Qualifier semantics: spec_valid_i and update_valid_i are single-cycle
// valid strobes with no ready/backpressure; the table accepts a strobe on the
// clk_i edge where it is high (training is silently dropped while
// init_busy_o or debug_mode_i is high, history pushes are always taken).
// mispredict_i is only meaningful together with update_valid_i.
interface bht_gshare_if #(
   parameter int unsigned VLEN            = 64,
   parameter int unsigned INSTR_PER_FETCH = 2,
   parameter int unsigned HIST_BITS       = 8
);
   logic                       flush_bp_i;
   logic                       debug_mode_i;
   logic [VLEN-1:0]            vpc_i;
   logic                       spec_valid_i;
   logic                       spec_taken_i;
   logic                       update_valid_i;
   logic [VLEN-1:0]            update_pc_i;
   logic                       update_taken_i;
   logic [HIST_BITS-1:0]       update_ghr_i;
   logic                       mispredict_i;
   logic [HIST_BITS-1:0]       ghr_o;
   logic [INSTR_PER_FETCH-1:0] pred_valid_o;
   logic [INSTR_PER_FETCH-1:0] pred_taken_o;
   logic                       init_busy_o;
   logic                       dbg_state_o;

   modport master (
      output flush_bp_i, debug_mode_i, vpc_i, spec_valid_i, spec_taken_i,
             update_valid_i, update_pc_i, update_taken_i, update_ghr_i,
             mispredict_i,
      input  ghr_o, pred_valid_o, pred_taken_o, init_busy_o, dbg_state_o
   );

   modport slave (
      input  flush_bp_i, debug_mode_i, vpc_i, spec_valid_i, spec_taken_i,
             update_valid_i, update_pc_i, update_taken_i, update_ghr_i,
             mispredict_i,
      output ghr_o, pred_valid_o, pred_taken_o, init_busy_o, dbg_state_o
   );
endinterface

// File: rtl/bht_gshare.sv
// bht_gshare: gshare-indexed branch history table with saturating counters.
//
// Ports:
//   clk_i  - clock
//   rst_i  - asynchronous reset, active-high
//   bp     - bht_gshare_if.slave: lookup PC, speculative history pushes,
//            training/mispredict updates, flush, debug mode in; per-slot
//            pred_valid_o/pred_taken_o, ghr_o snapshot, init_busy_o and
//            dbg_state_o (1 = CLEAR, 0 = IDLE) out.
//
// Each row holds INSTR_PER_FETCH entries of {valid, counter}. Rows are
// selected by PC bits XOR the global history. A clear engine walks the rows
// one per cycle after reset and after every flush; predictions read as
// invalid and training is ignored while it runs.
module bht_gshare #(
   parameter int unsigned VLEN            = 64,
   parameter int unsigned INSTR_PER_FETCH = 2,
   parameter bit          RVC             = 1'b1,
   parameter int unsigned NR_ENTRIES      = 1024,
   parameter int unsigned CTR_BITS        = 2,
   parameter int unsigned HIST_BITS       = 8
) (
   input  logic        clk_i,
   input  logic        rst_i,
   bht_gshare_if.slave bp
);

   localparam int unsigned OFFSET        = RVC ? 1 : 2;
   localparam int unsigned NR_ROWS       = NR_ENTRIES / INSTR_PER_FETCH;
   localparam int unsigned IDX_BITS      = $clog2(NR_ROWS);
   localparam int unsigned ROW_ADDR_BITS = $clog2(INSTR_PER_FETCH);
   localparam int unsigned COL_BITS      = (ROW_ADDR_BITS > 0) ? ROW_ADDR_BITS : 1;
   localparam int unsigned ROW_SHIFT     = ROW_ADDR_BITS + OFFSET;
   localparam int unsigned ENTRY_W       = CTR_BITS + 1;

   localparam logic [CTR_BITS-1:0] CTR_INIT = {1'b1, {(CTR_BITS-1){1'b0}}};
   localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;

   // Encoding chosen so dbg_state_o reads 1 exactly while clearing.
   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_e;

   state_e               state_q, state_d;
   logic [IDX_BITS-1:0]  clr_cnt_q, clr_cnt_d;
   logic [HIST_BITS-1:0] ghr_q, ghr_d;
   logic                 busy;

   assign busy = (state_q == CLEAR);

   // ---------------------------------------------------------------
   // Indexing
   // ---------------------------------------------------------------
   logic [VLEN-1:0]     rd_sh, up_sh, col_sh;
   logic [IDX_BITS-1:0] rd_row, up_row;
   logic [COL_BITS-1:0] up_col;

   assign rd_sh  = bp.vpc_i >> ROW_SHIFT;
   assign up_sh  = bp.update_pc_i >> ROW_SHIFT;
   assign col_sh = bp.update_pc_i >> OFFSET;

   // History is shorter than (or equal to) the index, so it only folds
   // into the low index bits.
   assign rd_row = rd_sh[IDX_BITS-1:0] ^ IDX_BITS'(ghr_q);
   assign up_row = up_sh[IDX_BITS-1:0] ^ IDX_BITS'(bp.update_ghr_i);

   // Without compressed instructions every branch trains column 0.
   assign up_col = (RVC && INSTR_PER_FETCH > 1) ? col_sh[COL_BITS-1:0] : '0;

   // ---------------------------------------------------------------
   // Storage: one RAM per column, two async read ports (lookup and
   // training read-modify-write), one write port. No reset; the clear
   // engine initialises it.
   // ---------------------------------------------------------------
   logic [INSTR_PER_FETCH-1:0][ENTRY_W-1:0] rd_ent, up_ent;
   logic [INSTR_PER_FETCH-1:0]              wr_en;
   logic [IDX_BITS-1:0]                     wr_row;
   logic [ENTRY_W-1:0]                      wr_data;

   for (genvar g = 0; g < INSTR_PER_FETCH; g++) begin : g_col
      logic [ENTRY_W-1:0] mem_q [NR_ROWS];

      always_ff @(posedge clk_i) begin
         if (wr_en[g]) mem_q[wr_row] <= wr_data;
      end

      assign rd_ent[g] = mem_q[rd_row];
      assign up_ent[g] = mem_q[up_row];
   end

   // ---------------------------------------------------------------
   // Training
   // ---------------------------------------------------------------
   logic                train_en;
   logic [CTR_BITS-1:0] old_ctr, new_ctr;

   assign train_en = bp.update_valid_i & ~bp.debug_mode_i & ~busy;
   assign old_ctr  = up_ent[up_col][CTR_BITS-1:0];

   always_comb begin
      new_ctr = old_ctr;
      if (bp.update_taken_i) begin
         if (old_ctr != CTR_MAX) new_ctr = old_ctr + CTR_BITS'(1);
      end else begin
         if (old_ctr != '0) new_ctr = old_ctr - CTR_BITS'(1);
      end
   end

   // Clearing owns the write port; a training request in that cycle is lost.
   always_comb begin
      wr_en   = '0;
      wr_row  = up_row;
      wr_data = {1'b1, new_ctr};
      if (busy) begin
         wr_en   = '1;
         wr_row  = clr_cnt_q;
         wr_data = {1'b0, CTR_INIT};
      end else if (train_en) begin
         wr_en[up_col] = 1'b1;
      end
   end

   // ---------------------------------------------------------------
   // Clear FSM
   // ---------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      case (state_q)
         CLEAR: begin
            clr_cnt_d = clr_cnt_q + IDX_BITS'(1);
            if (clr_cnt_q == IDX_BITS'(NR_ROWS - 1)) state_d = IDLE;
         end
         default: ;
      endcase
      if (bp.flush_bp_i) begin
         state_d   = CLEAR;
         clr_cnt_d = '0;
      end
   end

   // ---------------------------------------------------------------
   // Global history. The truncating casts keep the newest HIST_BITS of
   // {old history, new bit}, which also covers HIST_BITS == 1.
   // ---------------------------------------------------------------
   always_comb begin
      ghr_d = ghr_q;
      if (bp.flush_bp_i) begin
         ghr_d = '0;
      end else if (bp.update_valid_i && bp.mispredict_i) begin
         ghr_d = HIST_BITS'({bp.update_ghr_i, bp.update_taken_i});
      end else if (bp.spec_valid_i) begin
         ghr_d = HIST_BITS'({ghr_q, bp.spec_taken_i});
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= CLEAR;
         clr_cnt_q <= '0;
         ghr_q     <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
         ghr_q     <= ghr_d;
      end
   end

   // ---------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------
   logic [INSTR_PER_FETCH-1:0] pred_valid, pred_taken;

   always_comb begin
      pred_valid = '0;
      pred_taken = '0;
      if (!busy) begin
         for (int i = 0; i < INSTR_PER_FETCH; i++) begin
            pred_valid[i] = rd_ent[i][CTR_BITS];
            pred_taken[i] = rd_ent[i][CTR_BITS-1];
         end
      end
   end

   assign bp.pred_valid_o = pred_valid;
   assign bp.pred_taken_o = pred_taken;
   assign bp.ghr_o        = ghr_q;
   assign bp.init_busy_o  = busy;
   assign bp.dbg_state_o  = state_q;

   // High PC bits and the valid bit on the training read port are not needed.
   logic unused_bits;
   assign unused_bits = ^{rd_sh, up_sh, col_sh, up_ent};

endmodule

// File: tb/tb_bht_gshare.sv
// tb_bht_gshare: directed bench for bht_gshare, 8-row configuration
// (NR_ENTRIES=16, INSTR_PER_FETCH=2, RVC=1, HIST_BITS=3). A second instance
// with CTR_BITS=3 shares every input except update_valid_i.
module tb_bht_gshare;
   localparam int VLEN = 64;
   localparam int IPF  = 2;
   localparam int HB   = 3;

   // ---------------- clock / reset ----------------
   logic clk_i = 1'b0;
   logic rst_i;
   always #5 clk_i = ~clk_i;

   // ---------------- stimulus variables ----------------
   logic            flush, dbg, spec_v, spec_t, upd_v2, upd_v3, upd_t, mispred;
   logic [VLEN-1:0] vpc, upc;
   logic [HB-1:0]   ughr;

   bht_gshare_if #(.VLEN(VLEN), .INSTR_PER_FETCH(IPF), .HIST_BITS(HB)) bp2 ();
   bht_gshare_if #(.VLEN(VLEN), .INSTR_PER_FETCH(IPF), .HIST_BITS(HB)) bp3 ();

   assign bp2.flush_bp_i     = flush;
   assign bp2.debug_mode_i   = dbg;
   assign bp2.vpc_i          = vpc;
   assign bp2.spec_valid_i   = spec_v;
   assign bp2.spec_taken_i   = spec_t;
   assign bp2.update_valid_i = upd_v2;
   assign bp2.update_pc_i    = upc;
   assign bp2.update_taken_i = upd_t;
   assign bp2.update_ghr_i   = ughr;
   assign bp2.mispredict_i   = mispred;

   assign bp3.flush_bp_i     = flush;
   assign bp3.debug_mode_i   = dbg;
   assign bp3.vpc_i          = vpc;
   assign bp3.spec_valid_i   = spec_v;
   assign bp3.spec_taken_i   = spec_t;
   assign bp3.update_valid_i = upd_v3;
   assign bp3.update_pc_i    = upc;
   assign bp3.update_taken_i = upd_t;
   assign bp3.update_ghr_i   = ughr;
   assign bp3.mispredict_i   = mispred;

   bht_gshare #(
      .VLEN(VLEN), .INSTR_PER_FETCH(IPF), .RVC(1'b1), .NR_ENTRIES(16),
      .CTR_BITS(2), .HIST_BITS(HB)
   ) u_dut2 (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bp    (bp2)
   );

   bht_gshare #(
      .VLEN(VLEN), .INSTR_PER_FETCH(IPF), .RVC(1'b1), .NR_ENTRIES(16),
      .CTR_BITS(3), .HIST_BITS(HB)
   ) u_dut3 (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bp    (bp3)
   );

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_pred2(input string name, input logic [1:0] ev, input logic [1:0] et);
      check({name, " valid"}, 32'(bp2.pred_valid_o), 32'(ev));
      check({name, " taken"}, 32'(bp2.pred_taken_o), 32'(et));
   endtask

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_inputs();
      flush   = 1'b0; dbg    = 1'b0; spec_v = 1'b0; spec_t  = 1'b0;
      upd_v2  = 1'b0; upd_v3 = 1'b0; upd_t  = 1'b0; mispred = 1'b0;
      vpc     = '0;   upc    = '0;   ughr   = '0;
   endtask

   // ---------------- vector tables ----------------
   typedef struct {
      logic [VLEN-1:0] pc;
      logic            u2;
      logic            u3;
      logic            taken;
      logic [1:0]      e2v, e2t, e3v, e3t;
   } trn_t;

   trn_t trn [13];

   typedef struct {
      logic [VLEN-1:0] pc;
      logic [1:0]      ev, et;
   } lk_t;

   lk_t lk [16];

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin : main
      // Training at pc=0x8 (row 2, column 0) with ghr=0, then read back at vpc=0x8.
      // dut2 (2-bit): 10 ->11,11,11 ->10,01,00,00 ->01,10.
      trn[0]  = '{64'h8, 1'b1, 1'b0, 1'b1, 2'b01, 2'b11, 2'b00, 2'b11};
      trn[1]  = '{64'h8, 1'b1, 1'b0, 1'b1, 2'b01, 2'b11, 2'b00, 2'b11};
      trn[2]  = '{64'h8, 1'b1, 1'b0, 1'b1, 2'b01, 2'b11, 2'b00, 2'b11};
      trn[3]  = '{64'h8, 1'b1, 1'b0, 1'b0, 2'b01, 2'b11, 2'b00, 2'b11};
      trn[4]  = '{64'h8, 1'b1, 1'b0, 1'b0, 2'b01, 2'b10, 2'b00, 2'b11};
      trn[5]  = '{64'h8, 1'b1, 1'b0, 1'b0, 2'b01, 2'b10, 2'b00, 2'b11};
      trn[6]  = '{64'h8, 1'b1, 1'b0, 1'b0, 2'b01, 2'b10, 2'b00, 2'b11};
      trn[7]  = '{64'h8, 1'b1, 1'b0, 1'b1, 2'b01, 2'b10, 2'b00, 2'b11};
      trn[8]  = '{64'h8, 1'b1, 1'b0, 1'b1, 2'b01, 2'b11, 2'b00, 2'b11};
      // dut3 (3-bit): 100 ->101 ->100 ->011 ->100; dut2 stays at 10.
      trn[9]  = '{64'h8, 1'b0, 1'b1, 1'b1, 2'b01, 2'b11, 2'b01, 2'b11};
      trn[10] = '{64'h8, 1'b0, 1'b1, 1'b0, 2'b01, 2'b11, 2'b01, 2'b11};
      trn[11] = '{64'h8, 1'b0, 1'b1, 1'b0, 2'b01, 2'b11, 2'b01, 2'b10};
      trn[12] = '{64'h8, 1'b0, 1'b1, 1'b1, 2'b01, 2'b11, 2'b01, 2'b11};

      // After the initial clear every entry is {0, weakly taken}.
      for (int i = 0; i < 16; i++) lk[i] = '{VLEN'(i * 2), 2'b00, 2'b11};

      idle_inputs();
      rst_i = 1'b1;
      step();
      step();

      // ---- 1. reset state and clear ----
      vpc = 64'h8;
      #1;
      check("reset busy", 32'(bp2.init_busy_o), 32'd1);
      check("reset state", 32'(bp2.dbg_state_o), 32'd1);
      check("reset ghr", 32'(bp2.ghr_o), 32'd0);
      check_pred2("reset pred", 2'b00, 2'b00);

      rst_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("first clear busy %0d", k), 32'(bp2.init_busy_o), 32'd1);
         step();
      end
      // Reset in mid-clear restarts the walk from row 0.
      rst_i = 1'b1;
      #1;
      check("midclear reset busy", 32'(bp2.init_busy_o), 32'd1);
      step();
      rst_i = 1'b0;
      for (int k = 0; k < 8; k++) begin
         vpc = VLEN'(k * 4 + 2);
         #1;
         check($sformatf("clear busy %0d", k), 32'(bp2.init_busy_o), 32'd1);
         check_pred2($sformatf("clear pred %0d", k), 2'b00, 2'b00);
         step();
      end
      check("clear done busy", 32'(bp2.init_busy_o), 32'd0);
      check("clear done state", 32'(bp2.dbg_state_o), 32'd0);
      check("clear done busy dut3", 32'(bp3.init_busy_o), 32'd0);

      for (int i = 0; i < 16; i++) begin
         vpc = lk[i].pc;
         #1;
         check_pred2($sformatf("lookup vpc=%0h", lk[i].pc), lk[i].ev, lk[i].et);
         step();
      end

      // ---- 2. saturation, both counter widths ----
      for (int i = 0; i < 13; i++) begin
         upc    = trn[i].pc;
         upd_t  = trn[i].taken;
         upd_v2 = trn[i].u2;
         upd_v3 = trn[i].u3;
         vpc    = 64'h8;
         step();
         upd_v2 = 1'b0;
         upd_v3 = 1'b0;
         #1;
         check_pred2($sformatf("train[%0d] dut2", i), trn[i].e2v, trn[i].e2t);
         check($sformatf("train[%0d] dut3 valid", i), 32'(bp3.pred_valid_o), 32'(trn[i].e3v));
         check($sformatf("train[%0d] dut3 taken", i), 32'(bp3.pred_taken_o), 32'(trn[i].e3t));
      end

      // ---- 3. speculative history ----
      spec_v = 1'b1; spec_t = 1'b1;
      step();
      check("ghr after push 1", 32'(bp2.ghr_o), 32'd1);
      spec_t = 1'b0;
      step();
      spec_t = 1'b1;
      step();
      spec_v = 1'b0;
      #1;
      check("ghr after 1,0,1", 32'(bp2.ghr_o), 32'd5);
      check("ghr after 1,0,1 dut3", 32'(bp3.ghr_o), 32'd5);
      vpc = 64'h8;          // row 2^5 = 7, untrained
      #1;
      check_pred2("ghr-indexed vpc=8", 2'b00, 2'b11);
      upc = 64'h0; ughr = 3'b101; upd_t = 1'b1; upd_v2 = 1'b1;
      step();
      upd_v2 = 1'b0;
      vpc = 64'h0;
      #1;
      check_pred2("row5 trained vpc=0", 2'b01, 2'b11);
      check("ghr unchanged by update", 32'(bp2.ghr_o), 32'd5);
      vpc = 64'h14;         // row 5^5 = 0
      #1;
      check_pred2("vpc=0x14 row0", 2'b00, 2'b11);

      // ---- 4. mispredict recovery beats a same-cycle spec push ----
      spec_v = 1'b1; spec_t = 1'b1;
      upc = 64'h10; ughr = 3'b011; upd_t = 1'b0; mispred = 1'b1;
      upd_v2 = 1'b1; upd_v3 = 1'b1;
      step();
      spec_v = 1'b0; mispred = 1'b0; upd_v2 = 1'b0; upd_v3 = 1'b0;
      #1;
      check("mispredict ghr", 32'(bp2.ghr_o), 32'd6);
      check("mispredict ghr dut3", 32'(bp3.ghr_o), 32'd6);
      vpc = 64'h4;          // row 1^6 = 7: col0 trained to 01, col1 untouched
      #1;
      check_pred2("mispredict train row7", 2'b01, 2'b10);

      // ---- 5. flush during clear; update dropped while clearing ----
      flush = 1'b1;
      step();
      flush = 1'b0;
      #1;
      check("flush busy", 32'(bp2.init_busy_o), 32'd1);
      check("flush ghr", 32'(bp2.ghr_o), 32'd0);
      for (int j = 0; j < 3; j++) begin
         check($sformatf("flush clear busy %0d", j), 32'(bp2.init_busy_o), 32'd1);
         step();
      end
      flush = 1'b1;         // clear cycle 4
      step();
      flush = 1'b0;
      for (int j = 0; j < 8; j++) begin
         vpc = 64'h8;
         if (j == 5) begin
            upc = 64'h8; ughr = 3'b000; upd_t = 1'b1; upd_v2 = 1'b1;
         end
         #1;
         check($sformatf("restart busy %0d", j), 32'(bp2.init_busy_o), 32'd1);
         check_pred2($sformatf("restart pred %0d", j), 2'b00, 2'b00);
         step();
         upd_v2 = 1'b0;
      end
      check("restart done busy", 32'(bp2.init_busy_o), 32'd0);
      vpc = 64'h8;
      #1;
      check_pred2("dropped update row2", 2'b00, 2'b11);

      // ---- 6. debug mode and no-bypass ----
      upc = 64'hC; ughr = 3'b000; upd_t = 1'b0; upd_v2 = 1'b1;
      step();
      upd_v2 = 1'b0;
      vpc = 64'hC;
      #1;
      check_pred2("row3 trained nt", 2'b01, 2'b10);
      dbg = 1'b1;
      upc = 64'hC; ughr = 3'b000; upd_t = 1'b1; mispred = 1'b1; upd_v2 = 1'b1;
      step();
      upd_v2 = 1'b0; mispred = 1'b0;
      #1;
      check("debug ghr restore", 32'(bp2.ghr_o), 32'd1);
      vpc = 64'h8;          // row 2^1 = 3
      #1;
      check_pred2("debug update dropped", 2'b01, 2'b10);
      upd_t = 1'b0; mispred = 1'b1; upd_v2 = 1'b1;
      step();
      upd_v2 = 1'b0; mispred = 1'b0; dbg = 1'b0;
      #1;
      check("ghr back to 0", 32'(bp2.ghr_o), 32'd0);
      vpc = 64'hC;
      #1;
      check_pred2("row3 after debug", 2'b01, 2'b10);
      upc = 64'hC; upd_t = 1'b1; upd_v2 = 1'b1;
      #1;
      check_pred2("same-cycle read old", 2'b01, 2'b10);
      step();
      upd_v2 = 1'b0;
      #1;
      check_pred2("write visible next", 2'b01, 2'b11);

      // ---- report ----
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
